// File: rtl/eth_pkg.sv
// Shared Ethernet constants: CRC-32 parameters, preamble/SFD bytes and the receive state encoding.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [10:0] LEN_SAT       = 11'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/crc32_d8_next.sv
// One byte step of the Ethernet CRC-32, MSB-first register with the byte fed LSB first.
// Purely combinational; shared by the TX generator and the RX checker.
module crc32_d8_next (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_next_o
);
    import eth_pkg::*;

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data_i[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_next_o = c;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes 4 cycles late with FCS removed,
// and pulses per-frame CRC/length/PHY-error status. All outputs registered; no backpressure.
module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_done,
    output logic        rx_crc_ok,
    output logic        rx_len_err,
    output logic        rx_phy_err,
    output logic [10:0] rx_len
);
    import eth_pkg::*;

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    rx_state_t        state_q;
    logic [2:0]       pre_cnt_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [10:0]      len_q;
    logic [3:0][7:0]  dly_q;
    logic [2:0]       dly_cnt_q;
    logic             sof_pend_q;
    logic             phy_err_q;

    crc32_d8_next u_crc (
        .crc_i      (crc_q),
        .data_i     (gmii_rxd),
        .crc_next_o (crc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 3'd0;
            crc_q      <= CRC32_INIT;
            len_q      <= 11'd0;
            dly_q      <= '0;
            dly_cnt_q  <= 3'd0;
            sof_pend_q <= 1'b0;
            phy_err_q  <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_done    <= 1'b0;
            rx_crc_ok  <= 1'b0;
            rx_len_err <= 1'b0;
            rx_phy_err <= 1'b0;
            rx_len     <= 11'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_done  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == ETH_PREAMBLE) begin
                            state_q   <= ST_PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (gmii_rxd == ETH_PREAMBLE) begin
                        if (pre_cnt_q != 3'd7) begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (gmii_rxd == ETH_SFD && pre_cnt_q != 3'd0) begin
                        state_q    <= ST_DATA;
                        crc_q      <= CRC32_INIT;
                        len_q      <= 11'd0;
                        dly_cnt_q  <= 3'd0;
                        sof_pend_q <= 1'b1;
                        phy_err_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end

                ST_DATA: begin
                    if (gmii_rx_dv) begin
                        crc_q <= crc_d;
                        if (len_q != LEN_SAT) begin
                            len_q <= len_q + 11'd1;
                        end
                        if (gmii_rx_er) begin
                            phy_err_q <= 1'b1;
                        end
                        // Four-byte holdback so the FCS never reaches the parser.
                        dly_q <= {dly_q[2:0], gmii_rxd};
                        if (dly_cnt_q == 3'd4) begin
                            rx_data    <= dly_q[3];
                            rx_valid   <= 1'b1;
                            rx_sof     <= sof_pend_q;
                            sof_pend_q <= 1'b0;
                        end else begin
                            dly_cnt_q <= dly_cnt_q + 3'd1;
                        end
                    end else begin
                        state_q    <= ST_IDLE;
                        rx_done    <= 1'b1;
                        rx_crc_ok  <= (crc_q == CRC32_RESIDUE) && (len_q >= 11'd4);
                        rx_len_err <= (len_q < MIN_LEN_W) || (len_q > MAX_LEN_W);
                        rx_phy_err <= phy_err_q;
                        rx_len     <= len_q;
                    end
                end

                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Randomised self-checking bench for eth_rx_fcs_check against a byte-level reflected CRC-32 model.
module tb_eth_rx_fcs_check;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        crc_ok;
        logic        len_err;
        logic        phy_err;
        logic [10:0] len;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_done, rx_crc_ok, rx_len_err, rx_phy_err;
    logic [10:0] rx_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b0_edge = 0;
    int end_edge = 0;

    logic [7:0] out_q[$];
    logic       sof_q[$];
    int         ocyc_q[$];
    done_t      done_q[$];

    eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk        (clk),
        .reset      (reset),
        .gmii_rx_dv (dv),
        .gmii_rx_er (er),
        .gmii_rxd   (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_done    (rx_done),
        .rx_crc_ok  (rx_crc_ok),
        .rx_len_err (rx_len_err),
        .rx_phy_err (rx_phy_err),
        .rx_len     (rx_len)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            out_q.push_back(rx_data);
            sof_q.push_back(rx_sof);
            ocyc_q.push_back(cyc);
        end
        if (rx_done) done_q.push_back('{rx_crc_ok, rx_len_err, rx_phy_err, rx_len, cyc});
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d, required < 125000)", cyc);
        $fatal(1);
    end

    // Standard reflected Ethernet CRC over the first n bytes; returns the value sent as FCS.
    function automatic logic [31:0] calc_fcs(input bq_t b, input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_good(input int n_payload, input bit rnd);
        bq_t b;
        logic [31:0] f;
        for (int i = 0; i < n_payload; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
        f = calc_fcs(b, n_payload);
        for (int k = 0; k < 4; k++) b.push_back(f[8*k +: 8]);
        return b;
    endfunction

    function automatic done_t exp_status(input bq_t b, input logic phy);
        done_t r;
        int L = b.size();
        r.len     = (L > 2047) ? 11'h7FF : 11'(L);
        r.len_err = (L < 64) || (L > 1518);
        r.phy_err = phy;
        r.crc_ok  = 1'b0;
        r.cyc     = 0;
        if (L >= 4) r.crc_ok = ({b[L-1], b[L-2], b[L-3], b[L-4]} == calc_fcs(b, L - 4));
        return r;
    endfunction

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        @(negedge clk);
        dv = v; er = e; rxd = d;
    endtask

    task automatic send_frame(input bq_t body, input int npre, input int er_idx, input int gap);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < body.size(); i++) begin
            drive(1'b1, i == er_idx, body[i]);
            if (i == 0) b0_edge = cyc + 1;
        end
        drive(1'b0, 1'b0, 8'h00);
        end_edge = cyc + 1;
        for (int i = 1; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_caps();
        out_q = {}; sof_q = {}; ocyc_q = {}; done_q = {};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i == 1) ? 8'h55 : 8'hD5);
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_done, rx_crc_ok, rx_len_err, rx_phy_err, rx_len} !== '0) begin
            errors++;
            $display("FAIL reset_state: got data=%h v=%b sof=%b done=%b ok=%b lerr=%b perr=%b len=%0d, required all zero",
                     rx_data, rx_valid, rx_sof, rx_done, rx_crc_ok, rx_len_err, rx_phy_err, rx_len);
        end
        dv = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_crc_vector();
        bq_t body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                      8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_caps();
        send_frame(body, 7, -1, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (out_q.size() !== 9) begin
            errors++; $display("FAIL vec_count: got %0d bytes, required 9", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 9; i++) begin
            checks++;
            if (out_q[i] !== 8'(8'h31 + i) || sof_q[i] !== (i == 0)) begin
                errors++;
                $display("FAIL vec_byte%0d: got %h sof=%b, required %h sof=%b", i, out_q[i], sof_q[i], 8'(8'h31 + i), i == 0);
            end
        end
        checks++;
        if (ocyc_q.size() < 1 || ocyc_q[0] !== b0_edge + 4) begin
            errors++; $display("FAIL vec_latency: first byte at cycle %0d, required %0d", (ocyc_q.size() > 0) ? ocyc_q[0] : -1, b0_edge + 4);
        end
        checks++;
        if (done_q.size() !== 1) begin
            errors++; $display("FAIL vec_done_count: got %0d, required 1", done_q.size());
        end else begin
            checks++;
            if (done_q[0].crc_ok !== 1'b1 || done_q[0].len_err !== 1'b1 || done_q[0].phy_err !== 1'b0 ||
                done_q[0].len !== 11'd13 || done_q[0].cyc !== end_edge) begin
                errors++;
                $display("FAIL vec_status: got ok=%b lerr=%b perr=%b len=%0d cyc=%0d, required 1 1 0 13 cyc=%0d",
                         done_q[0].crc_ok, done_q[0].len_err, done_q[0].phy_err, done_q[0].len, done_q[0].cyc, end_edge);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rx_done !== 1'b0 || rx_len !== 11'd13 || rx_crc_ok !== 1'b1) begin
            errors++; $display("FAIL vec_hold: got done=%b len=%0d ok=%b, required 0 13 1", rx_done, rx_len, rx_crc_ok);
        end
    endtask

    task automatic run_64(input string name, input int flip_idx, input int er_idx);
        bq_t body = make_good(60, 1'b0);
        done_t e;
        if (flip_idx >= 0) body[flip_idx] = 8'hFF;
        e = exp_status(body, er_idx >= 0);
        clear_caps();
        send_frame(body, 7, er_idx, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (out_q.size() !== 60) begin
            errors++; $display("FAIL %s_count: got %0d bytes, required 60", name, out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 60; i++) begin
            checks++;
            if (out_q[i] !== body[i] || sof_q[i] !== (i == 0)) begin
                errors++; $display("FAIL %s_byte%0d: got %h sof=%b, required %h sof=%b", name, i, out_q[i], sof_q[i], body[i], i == 0);
            end
        end
        checks++;
        if (done_q.size() !== 1) begin
            errors++; $display("FAIL %s_done_count: got %0d, required 1", name, done_q.size());
        end else begin
            checks++;
            if (done_q[0].crc_ok !== e.crc_ok || done_q[0].len_err !== e.len_err ||
                done_q[0].phy_err !== e.phy_err || done_q[0].len !== e.len) begin
                errors++;
                $display("FAIL %s_status: got ok=%b lerr=%b perr=%b len=%0d, required ok=%b lerr=%b perr=%b len=%0d", name,
                         done_q[0].crc_ok, done_q[0].len_err, done_q[0].phy_err, done_q[0].len, e.crc_ok, e.len_err, e.phy_err, e.len);
            end
        end
    endtask

    task automatic test_min_frame();  run_64("min_frame", -1, -1); endtask
    task automatic test_bad_crc();    run_64("bad_crc",   10, -1); endtask
    task automatic test_phy_err();    run_64("phy_err",   -1, 20); endtask

    task automatic test_bad_preamble();
        clear_caps();
        drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h54);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (out_q.size() !== 0 || done_q.size() !== 0) begin
            errors++; $display("FAIL bad_preamble: got %0d bytes %0d done, required 0 0", out_q.size(), done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bq_t a = make_good(60, 1'b0);
        bq_t b = make_good(66, 1'b1);
        clear_caps();
        send_frame(a, 7, -1, 1);
        send_frame(b, 2, -1, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (done_q.size() !== 2 || out_q.size() !== 126) begin
            errors++; $display("FAIL b2b_count: got %0d done %0d bytes, required 2 126", done_q.size(), out_q.size());
        end else begin
            checks++;
            if (done_q[0].crc_ok !== 1'b1 || done_q[1].crc_ok !== 1'b1 || done_q[0].len !== 11'd64 ||
                done_q[1].len !== 11'd70 || out_q[60] !== b[0] || sof_q[60] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_status: got ok=%b/%b len=%0d/%0d byte60=%h sof=%b, required 1/1 64/70 %h 1",
                         done_q[0].crc_ok, done_q[1].crc_ok, done_q[0].len, done_q[1].len, out_q[60], sof_q[60], b[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bq_t body = make_good(60, 1'b0);
        clear_caps();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < body.size(); i++) begin
            @(negedge clk);
            if (i == 31) begin
                checks++;
                if ({rx_data, rx_valid, rx_sof, rx_done, rx_crc_ok, rx_len_err, rx_phy_err, rx_len} !== '0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs: got data=%h v=%b len=%0d, required all zero", rx_data, rx_valid, rx_len);
                end
            end
            reset = (i == 30);
            dv = 1'b1; er = 1'b0; rxd = body[i];
        end
        drive(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (out_q.size() !== 26 || done_q.size() !== 0) begin
            errors++; $display("FAIL mid_reset_abort: got %0d bytes %0d done, required 26 0", out_q.size(), done_q.size());
        end
        clear_caps();
        send_frame(body, 7, -1, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (done_q.size() !== 1 || out_q.size() !== 60) begin
            errors++; $display("FAIL mid_reset_recover: got %0d done %0d bytes, required 1 60", done_q.size(), out_q.size());
        end else begin
            checks++;
            if (done_q[0].crc_ok !== 1'b1 || done_q[0].len !== 11'd64 || sof_q[0] !== 1'b1) begin
                errors++; $display("FAIL mid_reset_status: got ok=%b len=%0d sof=%b, required 1 64 1", done_q[0].crc_ok, done_q[0].len, sof_q[0]);
            end
        end
    endtask

    task automatic test_len_bounds();
        int lens[5] = '{63, 64, 1518, 1519, 2050};
        for (int n = 0; n < 5; n++) begin
            bq_t body = make_good(lens[n] - 4, 1'b1);
            done_t e = exp_status(body, 1'b0);
            clear_caps();
            send_frame(body, 3, -1, 2);
            repeat (2) @(negedge clk);
            checks++;
            if (done_q.size() !== 1 || out_q.size() !== lens[n] - 4) begin
                errors++; $display("FAIL len%0d_count: got %0d done %0d bytes, required 1 %0d", lens[n], done_q.size(), out_q.size(), lens[n] - 4);
            end else begin
                checks++;
                if (done_q[0].len_err !== e.len_err || done_q[0].len !== e.len || done_q[0].crc_ok !== e.crc_ok) begin
                    errors++;
                    $display("FAIL len%0d_status: got lerr=%b len=%0d ok=%b, required lerr=%b len=%0d ok=%b", lens[n],
                             done_q[0].len_err, done_q[0].len, done_q[0].crc_ok, e.len_err, e.len, e.crc_ok);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_out[$];
        logic       exp_sof[$];
        done_t      exp_done[$];
        clear_caps();
        for (int f = 0; f < 25; f++) begin
            bq_t body;
            int L = $urandom_range(0, 100);
            int er_idx = -1;
            if (L >= 4) begin
                body = make_good(L - 4, 1'b1);
                if ($urandom_range(0, 3) == 0) body[$urandom_range(0, L - 1)] ^= 8'(1 << $urandom_range(0, 7));
            end else begin
                for (int i = 0; i < L; i++) body.push_back(8'($urandom));
            end
            if (L > 0 && $urandom_range(0, 4) == 0) er_idx = $urandom_range(0, L - 1);
            for (int i = 0; i + 4 < L; i++) begin
                exp_out.push_back(body[i]);
                exp_sof.push_back(i == 0);
            end
            exp_done.push_back(exp_status(body, er_idx >= 0));
            send_frame(body, $urandom_range(1, 7), er_idx, $urandom_range(1, 3));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_q.size() !== exp_out.size() || done_q.size() !== exp_done.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes %0d done, required %0d %0d", out_q.size(), done_q.size(), exp_out.size(), exp_done.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_out[i] || sof_q[i] !== exp_sof[i]) begin
                errors++; $display("FAIL rand_byte%0d: got %h sof=%b, required %h sof=%b", i, out_q[i], sof_q[i], exp_out[i], exp_sof[i]);
            end
        end
        for (int i = 0; i < done_q.size() && i < exp_done.size(); i++) begin
            checks++;
            if (done_q[i].crc_ok !== exp_done[i].crc_ok || done_q[i].len_err !== exp_done[i].len_err ||
                done_q[i].phy_err !== exp_done[i].phy_err || done_q[i].len !== exp_done[i].len) begin
                errors++;
                $display("FAIL rand_done%0d: got ok=%b lerr=%b perr=%b len=%0d, required ok=%b lerr=%b perr=%b len=%0d", i,
                         done_q[i].crc_ok, done_q[i].len_err, done_q[i].phy_err, done_q[i].len,
                         exp_done[i].crc_ok, exp_done[i].len_err, exp_done[i].phy_err, exp_done[i].len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_min_frame();
        test_bad_crc();
        test_phy_err();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        test_len_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
